counter_seq_ctrl: RTL

Sequencing controller for the team's small binary up counters.
- Owns a WIDTH-bit count register.
- Starts, pauses, stops and terminates the count against a programmable limit latched at start.
- Runs in one-shot or auto-reload mode and raises a single-cycle done pulse at terminal count.
- Used as the timing and sequence generator in front of downstream sequential blocks.

---
 rtl/counter_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a WIDTH-bit up counter: start/pause/stop against a limit latched at start,
// one-shot or auto-reload, one-cycle done pulse. Optional wrap counter: COUNTER_SEQ_CTRL_WRAPCNT_EN.
module counter_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
`ifdef COUNTER_SEQ_CTRL_WRAPCNT_EN
  output logic             done,
  output logic [7:0]       wrap_cnt
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_count, w_count_nxt;
  logic [WIDTH-1:0]   r_lim,   w_lim_nxt;
  logic               r_rld,   w_rld_nxt;
  logic               r_done,  w_done_nxt;
  logic               w_start_ok;
  logic               w_at_lim;
  logic               w_wrap_clr;
  logic               w_wrap_inc;

  // A start is only accepted with a non-zero limit and without a concurrent stop.
  assign w_start_ok = start && !stop && (limit != '0);
  assign w_at_lim   = (r_count == r_lim);

  // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_lim_nxt   = r_lim;
    w_rld_nxt   = r_rld;
    w_done_nxt  = 1'b0;
    w_wrap_clr  = 1'b0;
    w_wrap_inc  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_count_nxt = '0;
        if (w_start_ok) begin
          w_lim_nxt   = limit;
          w_rld_nxt   = reload;
          w_wrap_clr  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // Stop outranks the terminal count, so an aborted sequence never pulses done.
        if (stop) begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (en) begin
          if (w_at_lim) begin
            w_done_nxt = 1'b1;
            w_wrap_inc = 1'b1;
            if (r_rld) begin
              w_count_nxt = '0;
            end else begin
              w_state_nxt = ST_HOLD;
            end
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (stop) begin
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_start_ok) begin
          w_lim_nxt   = limit;
          w_rld_nxt   = reload;
          w_count_nxt = '0;
          w_wrap_clr  = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        w_count_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_lim   <= '0;
      r_rld   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_lim   <= w_lim_nxt;
      r_rld   <= w_rld_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;

`ifdef COUNTER_SEQ_CTRL_WRAPCNT_EN
  logic [7:0] r_wrap;

  always_ff @(posedge clk) begin
    if (rst || w_wrap_clr) begin
      r_wrap <= 8'd0;
    end else if (w_wrap_inc && (r_wrap != 8'hFF)) begin
      r_wrap <= r_wrap + 8'd1;
    end
  end

  assign wrap_cnt = r_wrap;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap_clr ^ w_wrap_inc;
`endif

endmodule
